// File: rtl/nrisc_multicycle_control.sv
// nrisc_multicycle_control
//   Multicycle control FSM for the 8-bit NRISC datapath. Every instruction is
//   sequenced through FETCH/DECODE/EXEC/MEM/WB. The FSM drives all datapath
//   enables and mux selects, waits on the memory handshake (with a timeout),
//   and reports halt/error status.
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   run        start/continue; sampled in IDLE and at instruction boundaries
//   opcode     IR[7:4], latched during DECODE
//   zero       ULA zero flag (used by BEQ in EXEC)
//   mem_ready  memory access completes this cycle
//   pc_write, sel_pc, ir_write, mem_read, mem_write, reg_write, sel_wb,
//   sel_ula_b, ula_op   datapath controls
//   halted, error       status (both absorbing until reset)
//   state_out           current state encoding
module nrisc_multicycle_control #(
  parameter int ULAOP_W     = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [3:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               sel_pc,
  output logic               ir_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic               sel_wb,
  output logic [1:0]         sel_ula_b,
  output logic [ULAOP_W-1:0] ula_op,
  output logic               halted,
  output logic               error,
  output logic [2:0]         state_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  localparam logic [3:0] OP_RMAX = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_LW   = 4'd6;
  localparam logic [3:0] OP_SW   = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam logic [ULAOP_W-1:0] ULA_ADD = ULAOP_W'(0);
  localparam logic [ULAOP_W-1:0] ULA_SUB = ULAOP_W'(1);

  state_t     state;
  state_t     next_state;
  state_t     after_instr;
  logic [3:0] op_q;
  logic [7:0] wait_cnt;
  logic       mem_wait;
  logic       timeout;

  // A wait cycle is a FETCH/MEM cycle without mem_ready. The cycle that would
  // bring the wait count to MEM_TIMEOUT is the last one tolerated. mem_ready
  // is checked first in next-state logic, so it wins over a coinciding timeout.
  assign mem_wait    = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;
  assign timeout     = mem_wait && (({1'b0, wait_cnt} + 9'd1) >= 9'(MEM_TIMEOUT));
  // run is only looked at when an instruction finishes.
  assign after_instr = run ? S_FETCH : S_IDLE;
  assign state_out   = state;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // Latched opcode and saturating wait counter (cleared on any state change)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q     <= '0;
      wait_cnt <= '0;
    end else begin
      if (state == S_DECODE) op_q <= opcode;
      if (next_state != state)                wait_cnt <= '0;
      else if (mem_wait && wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (run) next_state = S_FETCH;
      S_FETCH: begin
        if (mem_ready)    next_state = S_DECODE;
        else if (timeout) next_state = S_ERROR;
      end
      S_DECODE: begin
        if (opcode <= OP_BEQ)       next_state = S_EXEC;
        else if (opcode == OP_HALT) next_state = S_HALT;
        else                        next_state = S_ERROR;
      end
      S_EXEC: begin
        if (op_q == OP_BEQ)                         next_state = after_instr;
        else if (op_q == OP_LW || op_q == OP_SW)    next_state = S_MEM;
        else                                        next_state = S_WB;
      end
      S_MEM: begin
        if (mem_ready)    next_state = (op_q == OP_LW) ? S_WB : after_instr;
        else if (timeout) next_state = S_ERROR;
      end
      S_WB:     next_state = after_instr;
      S_HALT:   next_state = S_HALT;
      S_ERROR:  next_state = S_ERROR;
    endcase
  end

  // Output decode (state + latched opcode; handshake qualifies FETCH loads)
  always_comb begin
    pc_write  = 1'b0;
    sel_pc    = 1'b0;
    ir_write  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    sel_wb    = 1'b0;
    sel_ula_b = 2'd0;
    ula_op    = ULA_ADD;
    halted    = 1'b0;
    error     = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_EXEC: begin
        if (op_q == OP_BEQ) begin
          ula_op   = ULA_SUB;
          pc_write = zero;
          sel_pc   = 1'b1;
        end else if (op_q > OP_RMAX) begin
          ula_op    = ULA_ADD;
          sel_ula_b = 2'd1;
        end else begin
          ula_op = ULAOP_W'(op_q[2:0]);
        end
      end
      S_MEM: begin
        mem_read  = (op_q == OP_LW);
        mem_write = (op_q == OP_SW);
      end
      S_WB: begin
        reg_write = 1'b1;
        sel_wb    = (op_q == OP_LW);
      end
      S_HALT:  halted = 1'b1;
      S_ERROR: error  = 1'b1;
      default: ;
    endcase
  end

  // OP_ADDI documents the immediate group's lower bound alongside OP_RMAX.
  logic unused_addi;
  assign unused_addi = ^OP_ADDI;

endmodule

// File: tb/tb_nrisc_multicycle_control.sv
module tb_nrisc_multicycle_control;

  logic       clk = 1'b0;
  logic       reset, run, zero, mem_ready;
  logic [3:0] opcode;
  logic       pc_write, sel_pc, ir_write, mem_read, mem_write, reg_write, sel_wb;
  logic [1:0] sel_ula_b;
  logic [2:0] ula_op;
  logic       halted, error;
  logic [2:0] state_out;

  always #5 clk = ~clk;

  nrisc_multicycle_control #(.ULAOP_W(3), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .sel_pc(sel_pc),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .sel_wb(sel_wb), .sel_ula_b(sel_ula_b),
    .ula_op(ula_op), .halted(halted), .error(error), .state_out(state_out)
  );

  typedef struct packed {
    logic [2:0] st;
    logic pc_write, sel_pc, ir_write, mem_read, mem_write, reg_write, sel_wb;
    logic [1:0] sel_ula_b;
    logic [2:0] ula_op;
    logic halted, error;
  } obs_t;

  int    n_tests = 0;
  int    n_fail  = 0;
  obs_t  expq[$];
  string tagq[$];

  function automatic obs_t blank(input logic [2:0] st);
    obs_t o;
    o = '0;
    o.st = st;
    return o;
  endfunction

  function automatic logic [3:0] r4();
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Drive one cycle of inputs and queue the response expected in that cycle.
  task automatic step(input logic r, input logic [3:0] op, input logic z,
                      input logic mr, input obs_t e, input string tag);
    run = r; opcode = op; zero = z; mem_ready = mr;
    expq.push_back(e);
    tagq.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Monitor: compares whatever the DUT shows against the queued expectation.
  always @(negedge clk) begin
    obs_t  e;
    obs_t  a;
    string t;
    if (expq.size() != 0) begin
      e = expq.pop_front();
      t = tagq.pop_front();
      a = {state_out, pc_write, sel_pc, ir_write, mem_read, mem_write, reg_write,
           sel_wb, sel_ula_b, ula_op, halted, error};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got %h want %h", t, a, e);
      end
    end
  end

  // Instruction fetch (with fw wait cycles) followed by the decode cycle.
  task automatic fetch_decode(input logic [3:0] op, input int fw);
    obs_t e;
    for (int i = 0; i < fw; i++) begin
      e = blank(3'd1); e.mem_read = 1'b1;
      step(1'b1, r4(), rb(), 1'b0, e, "fetch_wait");
    end
    e = blank(3'd1); e.mem_read = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    step(1'b1, r4(), rb(), 1'b1, e, "fetch");
    e = blank(3'd2);
    step(1'b1, op, rb(), rb(), e, "decode");
  endtask

  // Reference behaviour for one legal instruction, written from the
  // instruction's semantics: what it needs from the ULA, memory and regfile.
  task automatic do_instr(input logic [3:0] op, input logic z, input int fw,
                          input int mw, input logic run_after);
    obs_t e;
    logic is_r, is_lw, is_sw, is_beq;
    is_r   = (op <= 4'd4);
    is_lw  = (op == 4'd6);
    is_sw  = (op == 4'd7);
    is_beq = (op == 4'd8);
    fetch_decode(op, fw);
    e = blank(3'd3);
    if (is_beq) begin
      e.ula_op = 3'd1; e.pc_write = z; e.sel_pc = 1'b1;
      step(run_after, r4(), z, rb(), e, "exec_beq");
    end else begin
      if (is_r) e.ula_op = op[2:0];
      else begin e.ula_op = 3'd0; e.sel_ula_b = 2'd1; end
      step(1'b1, r4(), rb(), rb(), e, "exec");
    end
    if (is_lw || is_sw) begin
      e = blank(3'd4); e.mem_read = is_lw; e.mem_write = is_sw;
      for (int i = 0; i < mw; i++) step(1'b1, r4(), rb(), 1'b0, e, "mem_wait");
      step(is_sw ? run_after : 1'b1, r4(), rb(), 1'b1, e, "mem");
    end
    if (!is_sw && !is_beq) begin
      e = blank(3'd5); e.reg_write = 1'b1; e.sel_wb = is_lw;
      step(run_after, r4(), rb(), rb(), e, "wb");
    end
    if (!run_after) step(1'b1, r4(), rb(), rb(), blank(3'd0), "idle_resume");
  endtask

  task automatic absorbing(input logic [2:0] st, input string tag);
    obs_t e;
    e = blank(st);
    e.halted = (st == 3'd6);
    e.error  = (st == 3'd7);
    for (int i = 0; i < 6; i++) step(rb(), r4(), rb(), rb(), e, tag);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(rb(), r4(), rb(), rb(), blank(3'd0), "reset_hold");
    reset = 1'b1;
    step(1'b1, r4(), rb(), rb(), blank(3'd0), "idle_go");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    obs_t e;
    int   fw, mw;
    reset = 1'b0; run = 1'b0; opcode = 4'd0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    // Reset held 3 clocks, then idle with run=0
    for (int i = 0; i < 3; i++) step(1'b0, r4(), rb(), rb(), blank(3'd0), "in_reset");
    reset = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b0, r4(), rb(), rb(), blank(3'd0), "idle_run0");
    step(1'b1, r4(), rb(), rb(), blank(3'd0), "idle_go");

    // Directed instructions
    do_instr(4'd0, 1'b0, 0, 0, 1'b1);   // ADD
    do_instr(4'd6, 1'b0, 0, 3, 1'b1);   // LW with 3 memory waits
    do_instr(4'd8, 1'b1, 0, 0, 1'b1);   // BEQ taken
    do_instr(4'd8, 1'b0, 0, 0, 1'b0);   // BEQ not taken, then pause
    do_instr(4'd7, 1'b0, 14, 14, 1'b1); // ready arrives on the timeout cycle
    do_instr(4'd4, 1'b0, 2, 0, 1'b0);   // SLT, then pause

    // Randomized legal instruction stream
    for (int n = 0; n < 60; n++) begin
      fw = ($urandom_range(0, 9) == 0) ? 14 : int'($urandom_range(0, 3));
      mw = ($urandom_range(0, 9) == 0) ? 14 : int'($urandom_range(0, 3));
      do_instr(4'($urandom_range(0, 8)), rb(), fw, mw, ($urandom_range(0, 2) != 0));
    end

    // Illegal opcode -> ERROR, absorbing through run toggles
    fetch_decode(4'd10, 0);
    absorbing(3'd7, "err_illegal");
    do_reset();

    // HALT
    fetch_decode(4'd15, 1);
    absorbing(3'd6, "halt");
    do_reset();

    // mem_ready stuck low in FETCH: 15 wait cycles, then ERROR
    e = blank(3'd1); e.mem_read = 1'b1;
    for (int i = 0; i < 15; i++) step(1'b1, r4(), rb(), 1'b0, e, "fetch_stuck");
    absorbing(3'd7, "err_timeout");
    do_reset();

    // Reset mid-MEM of a SW: write strobe must drop without a clock edge
    fetch_decode(4'd7, 0);
    e = blank(3'd3); e.sel_ula_b = 2'd1;
    step(1'b1, r4(), rb(), rb(), e, "exec_sw");
    mem_ready = 1'b0; run = 1'b1;
    #1;
    check("sw_mem_write_before", 32'(mem_write), 32'd1);
    check("sw_state_before", 32'(state_out), 32'd4);
    reset = 1'b0;
    #1;
    check("sw_mem_write_async", 32'(mem_write), 32'd0);
    check("sw_state_async", 32'(state_out), 32'd0);
    @(posedge clk);
    #1;
    do_reset();
    do_instr(4'd5, 1'b0, 0, 0, 1'b1);   // ADDI after recovery

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
